// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave shift engine.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: FSM state enum, TX underrun fill word, bit counter width helper.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } spi_slv_state_t;

  localparam int MAX_DATA_W = 32;

  // Bit counter must hold 0..data_w.
  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  // Word shifted out when the host has not supplied one in time: all ones.
  function automatic logic [MAX_DATA_W-1:0] UNDERRUN_FILL(input int data_w);
    logic [MAX_DATA_W-1:0] v_fill;
    v_fill = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) v_fill[i] = 1'b1;
    end
    return v_fill;
  endfunction

endpackage

// File: rtl/spi_tx_holdreg.sv
// TX holding register between the host and the SPI shifter.
// Latency: write lands next cycle; o_tx_rdy rises the cycle after a load.
// Backpressure: o_tx_rdy low while a word is held; loads never stall.
// Ports: i_clk/i_rst_n; i_tx_dat/i_tx_vld/o_tx_rdy host handshake (o_tx_rdy is
// also the empty indication); i_load consumes the word, o_load_dat is the word
// or the underrun fill pattern when empty.
module spi_tx_holdreg
  import spi_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_tx_dat,
  input  logic              i_tx_vld,
  output logic              o_tx_rdy,
  input  logic              i_load,
  output logic [DATA_W-1:0] o_load_dat
);

  localparam logic [DATA_W-1:0] FILL = DATA_W'(UNDERRUN_FILL(DATA_W));

  logic              r_full;
  logic [DATA_W-1:0] r_data;
  logic              w_wr;

  assign o_tx_rdy = ~r_full;
  assign w_wr     = i_tx_vld & ~r_full;

  // A write only happens while empty, so a load in the same cycle is an
  // underrun; the write wins and the word is kept for the next load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (w_wr) begin
      r_full <= 1'b1;
      r_data <= i_tx_dat;
    end else if (i_load) begin
      r_full <= 1'b0;
    end
  end

  assign o_load_dat = r_full ? r_data : FILL;

endmodule

// File: rtl/spi_slave_shift.sv
// SPI slave shift engine: MOSI deserializer and MISO serializer, all 4 modes.
// Latency: rx_valid_o one cycle after the last sample pulse; miso_o one cycle after a drive pulse.
// Backpressure: none on RX (words overwrite); TX via tx_valid_i/tx_ready_o holding register.
// Ports: clk_i/rst_ni; sclk_pe_i/sclk_ne_i synchronized edge pulses; cs_n_i, mosi_i levels;
// miso_o/miso_oe_o serial out; rx_data_o/rx_valid_o received word; tx_data_i/tx_valid_i/tx_ready_o.
// Optional macro SPI_SLV_ERR_FLAGS_EN adds tx_underrun_o and rx_partial_o pulses.
module spi_slave_shift
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_pe_i,
  input  logic              sclk_ne_i,
  input  logic              cs_n_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o
`ifdef SPI_SLV_ERR_FLAGS_EN
  ,
  output logic              tx_underrun_o,
  output logic              rx_partial_o
`endif
);

  localparam int               CNT_W = bit_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

  spi_slv_state_t    r_state;
  spi_slv_state_t    w_state_nxt;
  logic              r_cs_n_q;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_rx_sh;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_vld;
  logic [DATA_W-1:0] r_tx_sh;
  logic              r_miso;
  logic              r_miso_oe;

  logic              w_cs_fall;
  logic              w_sample_edge;
  logic              w_drive_edge;
  logic              w_start;
  logic              w_active;
  logic              w_end;
  logic              w_sample;
  logic              w_drive;
  logic              w_load;
  logic              w_shift;
  logic              w_last;
  logic [DATA_W-1:0] w_rx_next;
  logic [DATA_W-1:0] w_load_data;
  logic              w_tx_ready;

  // Modes 1 and 2 sample on the falling edge, modes 0 and 3 on the rising edge.
  assign w_sample_edge = (CPOL ^ CPHA) ? sclk_ne_i : sclk_pe_i;
  assign w_drive_edge  = (CPOL ^ CPHA) ? sclk_pe_i : sclk_ne_i;
  assign w_cs_fall     = r_cs_n_q & ~cs_n_i;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cs_fall) w_state_nxt = XFER;
      XFER:    if (cs_n_i)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. Deasserted CS overrides any edge pulse in the same cycle.
  always_comb begin
    w_start  = 1'b0;
    w_active = 1'b0;
    w_end    = 1'b0;
    case (r_state)
      IDLE:    w_start  = w_cs_fall;
      XFER: begin
        w_active = ~cs_n_i;
        w_end    = cs_n_i;
      end
      default: ;
    endcase
  end

  assign w_sample = w_active & w_sample_edge;
  assign w_drive  = w_active & w_drive_edge;
  assign w_last   = (r_bit_cnt == LAST);
  // CPHA=0 must present bit 0 before the first edge, so load on CS fall.
  // Afterwards a drive edge at bit_cnt==0 is the boundary of a new word.
  assign w_load   = (w_start & ~CPHA) | (w_drive & (r_bit_cnt == '0));
  assign w_shift  = w_drive & (r_bit_cnt != '0);

  assign w_rx_next = MSB_FIRST ? {r_rx_sh[DATA_W-2:0], mosi_i}
                               : {mosi_i, r_rx_sh[DATA_W-1:1]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cs_n_q  <= 1'b1;
      r_miso_oe <= 1'b0;
    end else begin
      r_cs_n_q  <= cs_n_i;
      r_miso_oe <= ~cs_n_i;
    end
  end

  // Bit counter and receive path
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bit_cnt <= '0;
      r_rx_sh   <= '0;
      r_rx_data <= '0;
      r_rx_vld  <= 1'b0;
    end else begin
      r_rx_vld <= w_sample & w_last;
      if (w_start || w_end) begin
        r_bit_cnt <= '0;
        r_rx_sh   <= '0;
      end else if (w_sample) begin
        r_rx_sh   <= w_rx_next;
        r_bit_cnt <= w_last ? '0 : r_bit_cnt + CNT_W'(1);
        if (w_last) r_rx_data <= w_rx_next;
      end
    end
  end

  // Transmit path: miso_o is the registered head of the shifter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_sh <= '0;
      r_miso  <= 1'b0;
    end else if (w_load) begin
      r_tx_sh <= w_load_data;
      r_miso  <= MSB_FIRST ? w_load_data[DATA_W-1] : w_load_data[0];
    end else if (w_shift) begin
      r_tx_sh <= MSB_FIRST ? (r_tx_sh << 1) : (r_tx_sh >> 1);
      r_miso  <= MSB_FIRST ? r_tx_sh[DATA_W-2] : r_tx_sh[1];
    end
  end

  spi_tx_holdreg #(
    .DATA_W (DATA_W)
  ) u_holdreg (
    .i_clk      (clk_i),
    .i_rst_n    (rst_ni),
    .i_tx_dat   (tx_data_i),
    .i_tx_vld   (tx_valid_i),
    .o_tx_rdy   (w_tx_ready),
    .i_load     (w_load),
    .o_load_dat (w_load_data)
  );

  assign miso_o     = r_miso;
  assign miso_oe_o  = r_miso_oe;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_vld;
  assign tx_ready_o = w_tx_ready;

`ifdef SPI_SLV_ERR_FLAGS_EN
  logic r_tx_underrun;
  logic r_rx_partial;

  // Ready high means the holding register is empty at the load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_underrun <= 1'b0;
      r_rx_partial  <= 1'b0;
    end else begin
      r_tx_underrun <= w_load & w_tx_ready;
      r_rx_partial  <= w_end & (r_bit_cnt != '0);
    end
  end

  assign tx_underrun_o = r_tx_underrun;
  assign rx_partial_o  = r_rx_partial;
`endif

endmodule
